serial_nibble_receiver: RTL and testbench

//   Framed serial-to-parallel receiver that assembles DATA_W-bit words from a 1-bit line.

---
 rtl/serial_nibble_receiver_pkg.sv | 22 ++
 rtl/serial_nibble_receiver_if.sv | 25 ++
 rtl/serial_nibble_receiver.sv | 124 ++++++++++++
 tb/tb_serial_nibble_receiver.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_nibble_receiver_pkg.sv
// Shared types and helpers for the framed serial nibble receiver.
// The FSM encoding and the parity rule live here so the RTL and any consumer agree on them.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Widest word par_calc accepts; callers zero-extend, which leaves the XOR unchanged.
  localparam int PAR_MAX_W = 32;

  // 1 when data plus the received parity bit match the selected parity sense.
  function automatic logic par_calc(input logic [PAR_MAX_W-1:0] data,
                                    input logic                 par_bit,
                                    input logic                 odd);
    return ((^data) ^ par_bit) == odd;
  endfunction

endpackage

// File: rtl/serial_nibble_receiver_if.sv
// Serial line, output word handshake and status pulses of the receiver.
// master = receiver side, slave = line driver / word consumer side.
interface serial_nibble_receiver_if #(
  parameter int DATA_W = 4
);
  logic              bit_tick;
  logic              sin;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport master (
    input  bit_tick, sin, out_ready,
    output out_data, out_valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    output bit_tick, sin, out_ready,
    input  out_data, out_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_nibble_receiver.sv
// Framed serial-to-parallel receiver: start(0), DATA_W bits LSB-first, optional parity, stop(1).
// One-entry output buffer with valid/ready; parity, framing and overrun reported as 1-cycle pulses.
module serial_nibble_receiver
  import rx_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  serial_nibble_receiver_if.master bus
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  logic stop_tick, par_ok, frame_good, consume, commit;

  // Frame evaluation only matters on the stop tick; elsewhere these are don't-care.
  assign stop_tick  = bus.bit_tick && (state_q == STOP);
  assign par_ok     = PARITY_EN ? par_calc(PAR_MAX_W'(shreg_q), par_q, PARITY_ODD) : 1'b1;
  assign frame_good = stop_tick && bus.sin && par_ok;
  assign consume    = out_valid_q && bus.out_ready;
  assign commit     = frame_good && (!out_valid_q || bus.out_ready);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: every transition is gated by bit_tick
  always_comb begin
    state_d = state_q;
    if (bus.bit_tick) begin
      unique case (state_q)
        IDLE:    if (!bus.sin) state_d = DATA;
        DATA:    if (bit_cnt_q == LAST_BIT) state_d = PARITY_EN ? PARITY : STOP;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath / output next-state
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    ovr_d       = 1'b0;

    if (bus.bit_tick) begin
      unique case (state_q)
        IDLE:   if (!bus.sin) bit_cnt_d = '0;
        DATA: begin
          shreg_d   = {bus.sin, shreg_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        PARITY: par_d = bus.sin;
        STOP: begin
          ferr_d = !bus.sin;
          perr_d = !par_ok;
        end
        default: ;
      endcase
    end

    // A same-cycle consume lets the new word replace the held one without a bubble.
    if (commit) begin
      out_data_d  = shreg_q;
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end

    ovr_d = frame_good && out_valid_q && !bus.out_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_nibble_receiver.sv
// Bench for serial_nibble_receiver: directed scenarios plus randomized frames,
// scored against a frame-level model through word and error-event queues.
module tb_serial_nibble_receiver;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serial_nibble_receiver_if #(.DATA_W(4)) bus();

  serial_nibble_receiver #(
    .DATA_W(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [3:0] wq[$];   // words expected to be handed over, in order
  logic [2:0] eq[$];   // {overrun, frame_err, parity_err} pulses expected, in order
  bit         m_held    = 1'b0;
  bit         rnd_ready = 1'b0;
  logic [3:0] mon_w;
  logic [2:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake and every status pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL word_unexpected: got %0h expected none", bus.out_data);
        end else begin
          mon_w = wq.pop_front();
          check("word", bus.out_data, mon_w);
        end
      end
      if (bus.parity_err || bus.frame_err || bus.overrun) begin
        if (eq.size() == 0) begin
          tests++; fails++;
          $display("FAIL event_unexpected: got %0b expected none",
                   {bus.overrun, bus.frame_err, bus.parity_err});
        end else begin
          mon_e = eq.pop_front();
          check("event", {bus.overrun, bus.frame_err, bus.parity_err}, mon_e);
        end
      end
    end
  end

  // One clock of stimulus; the model judges a frame when its stop tick is driven.
  task automatic cyc(input bit tick, input bit s, input bit is_stop,
                     input logic [3:0] w, input bit bad_par);
    bit ferr, good;
    if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    bus.bit_tick = tick;
    bus.sin      = s;
    ferr = is_stop && !s;
    good = is_stop && !ferr && !bad_par;
    if (is_stop && (ferr || bad_par)) eq.push_back({1'b0, ferr, bad_par});
    if (good && (!m_held || bus.out_ready)) begin
      wq.push_back(w);
      m_held = 1'b1;
    end else begin
      if (good) eq.push_back(3'b100);
      if (m_held && bus.out_ready) m_held = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
  endtask

  // Whole frame, one bit every `gap` clocks; returns just after the stop-tick edge.
  task automatic send_frame(input logic [3:0] w, input bit flip, input bit stopb, input int gap);
    logic [6:0] seq;
    seq = {stopb, (^w) ^ flip, w, 1'b0};
    for (int i = 0; i < 7; i++) begin
      for (int g = 1; g < gap; g++) cyc(1'b0, seq[i], 1'b0, w, flip);
      cyc(1'b1, seq[i], (i == 6), w, flip);
    end
  endtask

  initial begin
    bus.bit_tick  = 1'b0;
    bus.sin       = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid",  bus.out_valid, 0);
    check("rst_out_data",   bus.out_data, 0);
    check("rst_busy",       bus.busy, 0);
    check("rst_parity_err", bus.parity_err, 0);
    check("rst_frame_err",  bus.frame_err, 0);
    check("rst_overrun",    bus.overrun, 0);
    reset = 1'b1;
    idle(2);

    // Good even-parity frame
    bus.out_ready = 1'b1;
    send_frame(4'hD, 1'b0, 1'b1, 1);
    check("t1_valid", bus.out_valid, 1);
    check("t1_data",  bus.out_data, 4'hD);
    check("t1_noerr", {bus.parity_err, bus.frame_err}, 0);
    idle(1);

    // Stop bit low
    send_frame(4'hD, 1'b0, 1'b0, 1);
    check("t2_ferr",  bus.frame_err, 1);
    check("t2_valid", bus.out_valid, 0);
    idle(1);
    check("t2_ferr_1cyc", bus.frame_err, 0);
    check("t2_busy",      bus.busy, 0);

    // Wrong parity, then a good frame
    send_frame(4'hD, 1'b1, 1'b1, 1);
    check("t3_perr",  bus.parity_err, 1);
    check("t3_valid", bus.out_valid, 0);
    send_frame(4'h6, 1'b0, 1'b1, 1);
    check("t3_valid2", bus.out_valid, 1);
    check("t3_data2",  bus.out_data, 4'h6);
    idle(1);

    // Overrun with consumer stalled
    bus.out_ready = 1'b0;
    send_frame(4'h3, 1'b0, 1'b1, 1);
    send_frame(4'hA, 1'b0, 1'b1, 1);
    check("t4_ovr",   bus.overrun, 1);
    check("t4_data",  bus.out_data, 4'h3);
    check("t4_valid", bus.out_valid, 1);
    idle(1);
    check("t4_ovr_1cyc", bus.overrun, 0);
    bus.out_ready = 1'b1;
    idle(1);
    check("t4_drop", bus.out_valid, 0);

    // Reset mid-frame with a held word
    bus.out_ready = 1'b0;
    send_frame(4'h5, 1'b0, 1'b1, 1);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    check("t5_busy_pre", bus.busy, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_busy",  bus.busy, 0);
    check("t5_valid", bus.out_valid, 0);
    check("t5_data",  bus.out_data, 0);
    wq.delete(); eq.delete(); m_held = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    idle(1);
    send_frame(4'h9, 1'b0, 1'b1, 1);
    check("t5_valid2", bus.out_valid, 1);
    check("t5_data2",  bus.out_data, 4'h9);
    idle(1);

    // Slow ticks; a low glitch between ticks in IDLE must not start a frame
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    check("t6_glitch", bus.busy, 0);
    send_frame(4'hF, 1'b0, 1'b1, 4);
    check("t6_valid", bus.out_valid, 1);
    check("t6_data",  bus.out_data, 4'hF);
    check("t6_busy",  bus.busy, 0);
    idle(1);

    // Random frames, random consumer back-pressure
    rnd_ready = 1'b1;
    for (int f = 0; f < 80; f++) begin
      send_frame(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) != 0),
                 $urandom_range(1, 3));
      for (int k = $urandom_range(0, 2); k > 0; k--)
        cyc(1'($urandom_range(0, 1)), 1'b1, 1'b0, 4'h0, 1'b0);
    end

    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);
    check("drain_words",  wq.size(), 0);
    check("drain_events", eq.size(), 0);
    check("drain_valid",  bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
